// File: rtl/xmpl_fft_pkg.sv
// Shared types and constants for the FFT engine scheduler: FSM state encoding,
// status word bit positions and default field widths.
package xmpl_fft_pkg;

  localparam int unsigned LEN_W_DEF = 12;
  localparam int unsigned TMO_W_DEF = 16;
  localparam int unsigned OWNER_W   = 4;
  localparam int unsigned FCNT_W    = 16;

  // Encoding is visible to software through status_o[2:0]
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_FIN   = 3'd3,
    ST_ABORT = 3'd4
  } state_e;

  localparam int unsigned STAT_STATE_LSB  = 0;
  localparam int unsigned STAT_BUSY_BIT   = 3;
  localparam int unsigned STAT_OWNER_LSB  = 4;
  localparam int unsigned STAT_STICKY_BIT = 8;
  localparam int unsigned STAT_FCNT_LSB   = 16;

endpackage

// File: rtl/xmpl_fft_sched_if.sv
// Handshake between the scheduler (master) and the shared FFT engine (slave).
interface xmpl_fft_sched_if
  import xmpl_fft_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
);
  logic             fft_start_o;
  logic [LEN_W-1:0] fft_len_o;
  logic             fft_abort_o;
  logic             fft_busy_i;
  logic             fft_done_i;

  modport master (
    output fft_start_o, fft_len_o, fft_abort_o,
    input  fft_busy_i,  fft_done_i
  );

  modport slave (
    input  fft_start_o, fft_len_o, fft_abort_o,
    output fft_busy_i,  fft_done_i
  );
endinterface

// File: rtl/xmpl_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module xmpl_rr_arb
  import xmpl_fft_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [OWNER_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [OWNER_W-1:0] idx_o,
  output logic               valid_o
);

  // Pass one searches [ptr, NUM_REQ); pass two takes the lowest index as the wrap.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && req_i[i] && (OWNER_W'(i) >= ptr_i)) begin
        valid_o  = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = OWNER_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && req_i[i]) begin
        valid_o  = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = OWNER_W'(i);
      end
    end
  end

endmodule

// File: rtl/xmpl_fft_sched.sv
// Round-robin scheduler sharing one FFT engine among NUM_REQ requesters.
// Optional frame counter on status_o[31:16] with XMPL_FFT_SCHED_STATS_EN.
module xmpl_fft_sched
  import xmpl_fft_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned TMO_W   = TMO_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*LEN_W-1:0] len_i,
  input  logic [TMO_W-1:0]         timeout_i,
  input  logic                     clr_err_i,
  xmpl_fft_sched_if.master         fft,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     err_o,
  output logic [31:0]              status_o
);

  state_e             state_q,  state_d;
  logic [OWNER_W-1:0] ptr_q,    ptr_d;
  logic [OWNER_W-1:0] owner_q,  owner_d;
  logic [LEN_W-1:0]   len_q,    len_d;
  logic [TMO_W-1:0]   cnt_q,    cnt_d;
  logic               sticky_q, sticky_d;
  logic [NUM_REQ-1:0] grant_q,  grant_d;
  logic               start_q,  start_d;
  logic               abort_q,  abort_d;
  logic [NUM_REQ-1:0] done_q,   done_d;
  logic               err_q,    err_d;
  logic [FCNT_W-1:0]  frame_cnt;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [OWNER_W-1:0] arb_idx;
  logic               arb_valid;
  logic [LEN_W-1:0]   pick_len;

  xmpl_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    pick_len = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) pick_len = len_i[i*LEN_W +: LEN_W];
    end
  end

  // Outputs are registered, so each state's outputs are loaded on entry to it.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    done_d   = '0;
    err_d    = 1'b0;
    sticky_d = clr_err_i ? 1'b0 : sticky_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          owner_d = arb_idx;
          len_d   = pick_len;
          if (pick_len == '0) begin
            state_d = ST_FIN;
            done_d  = arb_gnt;
            err_d   = 1'b1;
          end else begin
            state_d = ST_START;
            start_d = 1'b1;
            grant_d = arb_gnt;
          end
        end
      end
      ST_START: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        cnt_d = cnt_q + TMO_W'(1);
        if (fft.fft_done_i) begin
          state_d = ST_FIN;
          done_d  = grant_q;
          grant_d = '0;
        end else if ((timeout_i != '0) && (cnt_q == timeout_i - TMO_W'(1))) begin
          state_d  = ST_ABORT;
          abort_d  = 1'b1;
          sticky_d = 1'b1;
        end
      end
      ST_ABORT: begin
        state_d = ST_FIN;
        done_d  = grant_q;
        err_d   = 1'b1;
        grant_d = '0;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        ptr_d   = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      grant_q  <= '0;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      grant_q  <= grant_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef XMPL_FFT_SCHED_STATS_EN
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if ((state_q == ST_FIN) && !err_q) fcnt_d = fcnt_q + FCNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) fcnt_q <= '0;
    else         fcnt_q <= fcnt_d;
  end

  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = '0;
`endif

  assign grant_o         = grant_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign fft.fft_start_o = start_q;
  assign fft.fft_len_o   = len_q;
  assign fft.fft_abort_o = abort_q;

  always_comb begin
    status_o                               = '0;
    status_o[STAT_STATE_LSB +: 3]          = state_q;
    status_o[STAT_BUSY_BIT]                = fft.fft_busy_i;
    status_o[STAT_OWNER_LSB +: OWNER_W]    = owner_q;
    status_o[STAT_STICKY_BIT]              = sticky_q;
    status_o[STAT_FCNT_LSB +: FCNT_W]      = frame_cnt;
  end

endmodule

// File: tb/tb_xmpl_fft_sched.sv
// Scoreboard bench for xmpl_fft_sched: expected starts/completions are queued
// when a request is driven and popped by a monitor when the DUT pulses them.
module tb_xmpl_fft_sched;
  import xmpl_fft_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned LW = 12;
  localparam int unsigned TW = 16;

  logic             clk_i     = 1'b0;
  logic             reset_i   = 1'b1;
  logic [NR-1:0]    req_i     = '0;
  logic [NR*LW-1:0] len_i     = '0;
  logic [TW-1:0]    timeout_i = '0;
  logic             clr_err_i = 1'b0;
  logic [NR-1:0]    grant_o;
  logic [NR-1:0]    done_o;
  logic             err_o;
  logic [31:0]      status_o;

  xmpl_fft_sched_if #(.LEN_W(LW)) fft_if ();

  xmpl_fft_sched #(.NUM_REQ(NR), .LEN_W(LW), .TMO_W(TW)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (req_i),
    .len_i     (len_i),
    .timeout_i (timeout_i),
    .clr_err_i (clr_err_i),
    .fft       (fft_if),
    .grant_o   (grant_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .status_o  (status_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [NR-1:0] vec;
    logic [LW-1:0] len;
    logic          err;
  } exp_t;

  exp_t start_q[$];
  exp_t done_q[$];
  int checks = 0, failures = 0;
  int start_cnt = 0, done_cnt = 0, abort_cnt = 0, ok_frames = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_len(input int unsigned k, input logic [LW-1:0] v);
    for (int unsigned i = 0; i < NR; i++) if (i == k) len_i[i*LW +: LW] = v;
  endtask

  task automatic push_start(input logic [NR-1:0] vec, input logic [LW-1:0] len);
    exp_t e;
    e.vec = vec; e.len = len; e.err = 1'b0;
    start_q.push_back(e);
  endtask

  task automatic push_done(input logic [NR-1:0] vec, input logic err);
    exp_t e;
    e.vec = vec; e.len = '0; e.err = err;
    done_q.push_back(e);
    if (!err) ok_frames++;
  endtask

  // which: 0 = fft_start_o, 1 = done_o, 2 = fft_abort_o; n counts negedges waited
  task automatic wait_ev(input int which, input string tag, output int n);
    bit hit;
    n = 0; hit = 1'b0;
    while (!hit && n < 100) begin
      @(negedge clk_i);
      n++;
      case (which)
        0:       hit = fft_if.fft_start_o;
        1:       hit = |done_o;
        default: hit = fft_if.fft_abort_o;
      endcase
    end
    check({tag, "_seen"}, {31'b0, hit}, 32'd1);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick(); tick();
    reset_i   = 1'b0;
    ok_frames = 0;
  endtask

  function automatic logic [15:0] exp_fcnt();
`ifdef XMPL_FFT_SCHED_STATS_EN
    return 16'(ok_frames);
`else
    return 16'd0;
`endif
  endfunction

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (fft_if.fft_start_o) begin
        exp_t e;
        start_cnt++;
        if (start_q.size() == 0) check("start_unexpected", {31'b0, fft_if.fft_start_o}, 32'd0);
        else begin
          e = start_q.pop_front();
          check("start_grant", {28'b0, grant_o}, {28'b0, e.vec});
          check("start_len", {20'b0, fft_if.fft_len_o}, {20'b0, e.len});
        end
      end
      if (|done_o) begin
        exp_t e;
        done_cnt++;
        if (done_q.size() == 0) check("done_unexpected", {28'b0, done_o}, 32'd0);
        else begin
          e = done_q.pop_front();
          check("done_vec", {28'b0, done_o}, {28'b0, e.vec});
          check("done_err", {31'b0, err_o}, {31'b0, e.err});
        end
      end else if (err_o) check("err_without_done", {31'b0, err_o}, 32'd0);
      if (fft_if.fft_abort_o) abort_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0, s0, d0;
    logic [NR-1:0] v;
    fft_if.fft_done_i = 1'b0;
    fft_if.fft_busy_i = 1'b0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_grant",  {28'b0, grant_o}, 32'd0);
    check("rst_done",   {28'b0, done_o}, 32'd0);
    check("rst_err",    {31'b0, err_o}, 32'd0);
    check("rst_start",  {31'b0, fft_if.fft_start_o}, 32'd0);
    check("rst_abort",  {31'b0, fft_if.fft_abort_o}, 32'd0);
    check("rst_len",    {20'b0, fft_if.fft_len_o}, 32'd0);
    check("rst_status", status_o, 32'd0);
    tick();
    reset_i = 1'b0;

    // Single frame, done after 10 RUN cycles; late len change must be ignored
    set_len(0, 12'd256);
    push_start(4'b0001, 12'd256);
    push_done(4'b0001, 1'b0);
    req_i = 4'b0001;
    wait_ev(0, "t1_start", n);
    check("t1_start_latency", n, 32'd2);
    set_len(0, 12'd99);
    repeat (9) tick();
    @(negedge clk_i);
    check("t1_len_hold", {20'b0, fft_if.fft_len_o}, 32'd256);
    check("t1_state_run", {29'b0, status_o[2:0]}, 32'd2);
    check("t1_grant_run", {28'b0, grant_o}, 32'd1);
    tick();
    fft_if.fft_done_i = 1'b1;
    tick();
    fft_if.fft_done_i = 1'b0;
    wait_ev(1, "t1_done", n);
    check("t1_done_latency", n, 32'd1);
    check("t1_fin_grant", {28'b0, grant_o}, 32'd0);
    tick();
    req_i = '0;

    // All four requesting, immediate done: grant order 0,1,2,3,0
    do_reset();
    for (int unsigned k = 0; k < NR; k++) set_len(k, LW'(16 * (k + 1)));
    for (int f = 0; f < 5; f++) begin
      v = '0;
      v[f % 4] = 1'b1;
      push_start(v, LW'(16 * ((f % 4) + 1)));
      push_done(v, 1'b0);
    end
    req_i = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_ev(0, "t2_start", n);
      tick();
      fft_if.fft_done_i = 1'b1;
      tick();
      fft_if.fft_done_i = 1'b0;
      wait_ev(1, "t2_done", n);
    end
    tick();
    req_i = '0;

    // Timeout with no engine done: abort, error completion, sticky flag
    set_len(2, 12'd100);
    timeout_i = 16'd5;
    fft_if.fft_busy_i = 1'b1;
    push_start(4'b0100, 12'd100);
    push_done(4'b0100, 1'b1);
    req_i = 4'b0100;
    wait_ev(0, "t3_start", n);
    a0 = abort_cnt;
    wait_ev(2, "t3_abort", n);
    check("t3_abort_latency", n, 32'd6);
    check("t3_state_abort", {29'b0, status_o[2:0]}, 32'd4);
    check("t3_sticky_set", {31'b0, status_o[8]}, 32'd1);
    check("t3_busy", {31'b0, status_o[3]}, 32'd1);
    check("t3_owner", {28'b0, status_o[7:4]}, 32'd2);
    wait_ev(1, "t3_done", n);
    check("t3_done_latency", n, 32'd1);
    tick();
    req_i = '0;
    fft_if.fft_busy_i = 1'b0;
    @(negedge clk_i);
    check("t3_sticky_hold", {31'b0, status_o[8]}, 32'd1);
    check("t3_abort_once", abort_cnt - a0, 32'd1);
    tick();
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    @(negedge clk_i);
    check("t3_sticky_clr", {31'b0, status_o[8]}, 32'd0);
    tick();

    // Done on the 5th RUN cycle beats the timeout; requester drops req mid-frame
    set_len(3, 12'd7);
    push_start(4'b1000, 12'd7);
    push_done(4'b1000, 1'b0);
    req_i = 4'b1000;
    wait_ev(0, "t4_start", n);
    a0 = abort_cnt;
    tick(); tick();
    req_i = '0;
    tick(); tick(); tick();
    fft_if.fft_done_i = 1'b1;
    tick();
    fft_if.fft_done_i = 1'b0;
    wait_ev(1, "t4_done", n);
    check("t4_done_latency", n, 32'd1);
    check("t4_no_abort", abort_cnt - a0, 32'd0);
    check("t4_sticky_clear", {31'b0, status_o[8]}, 32'd0);
    tick();

    // Zero length: straight to an error completion, no engine start
    timeout_i = '0;
    set_len(1, 12'd0);
    s0 = start_cnt;
    push_done(4'b0010, 1'b1);
    req_i = 4'b0010;
    wait_ev(1, "t5_done", n);
    check("t5_done_latency", n, 32'd2);
    check("t5_owner", {28'b0, status_o[7:4]}, 32'd1);
    check("t5_state_fin", {29'b0, status_o[2:0]}, 32'd3);
    tick();
    req_i = '0;
    check("t5_no_start", start_cnt - s0, 32'd0);
    @(negedge clk_i);
    check("stats_before_reset", {16'b0, status_o[31:16]}, {16'b0, exp_fcnt()});
    tick();

    // Reset during RUN: asynchronous clear, no completion issued
    set_len(0, 12'd50);
    push_start(4'b0001, 12'd50);
    req_i = 4'b0001;
    wait_ev(0, "t6_start", n);
    tick();
    d0 = done_cnt;
    reset_i = 1'b1;
    #1;
    check("t6_grant_async", {28'b0, grant_o}, 32'd0);
    check("t6_status_async", status_o, 32'd0);
    req_i = '0;
    tick(); tick();
    reset_i   = 1'b0;
    ok_frames = 0;
    repeat (3) tick();
    check("t6_no_done", done_cnt - d0, 32'd0);

    // Three successful frames for the frame counter
    for (int f = 0; f < 3; f++) begin
      push_start(4'b0100, 12'd100);
      push_done(4'b0100, 1'b0);
      req_i = 4'b0100;
      wait_ev(0, "t7_start", n);
      tick();
      fft_if.fft_done_i = 1'b1;
      tick();
      fft_if.fft_done_i = 1'b0;
      wait_ev(1, "t7_done", n);
      tick();
      req_i = '0;
    end
    @(negedge clk_i);
    check("t7_frame_count", {16'b0, status_o[31:16]}, {16'b0, exp_fcnt()});
    check("t7_idle", {29'b0, status_o[2:0]}, 32'd0);

    repeat (3) tick();
    check("sb_start_left", start_q.size(), 32'd0);
    check("sb_done_left", done_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xmpl_fft_sched.md
Name: xmpl_fft_sched

Overview:
- Round-robin scheduler that shares one FFT engine among NUM_REQ requesters inside the DSP core.
- Per frame: grants one requester, loads its frame length, pulses the engine start, then waits for engine done or a timeout.
- Reports completion to the owner and exposes a 32-bit status word to the register block.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- LEN_W, 12, frame-length width; matches the FFT length/config field.
- TMO_W, 16, timeout counter width.

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  request per requester; held until matching done_o.
- len_i  in  NUM_REQ*LEN_W  packed frame lengths; slice k belongs to req_i[k].
- timeout_i  in  TMO_W  max RUN cycles; 0 disables the timeout.
- clr_err_i  in  1  clears the sticky timeout flag.
- fft_busy_i  in  1  engine busy (status only).
- fft_done_i  in  1  engine frame-complete pulse.
- grant_o  out  NUM_REQ  one-hot owner; all zero when idle.
- fft_start_o  out  1  one-cycle engine start.
- fft_len_o  out  LEN_W  registered length of the current owner.
- fft_abort_o  out  1  one-cycle abort on timeout.
- done_o  out  NUM_REQ  one-cycle completion pulse to the owner.
- err_o  out  1  one-cycle pulse, coincident with done_o, when the frame failed.
- status_o  out  32  status word.

Behaviour:
- Reset: every output 0; state IDLE; RR pointer 0; counters 0; sticky flag 0.
- FSM states: IDLE, START, RUN, FIN, ABORT.
- IDLE:
  - If any req_i is high, pick the first requester at or after the pointer, wrapping around.
  - Latch its index and its len_i slice.
  - If the latched length is 0, go to FIN with an error.
  - Otherwise go to START.
- START:
  - grant_o is one-hot, fft_len_o is valid, fft_start_o = 1 for exactly this cycle.
  - Next state is RUN.
  - Latency: req_i seen high in IDLE at cycle N gives fft_start_o at cycle N+1.
- RUN:
  - grant_o is held and the timeout counter increments every cycle.
  - fft_done_i goes to FIN (success).
  - If timeout_i != 0 and the counter equals timeout_i-1 with no done, go to ABORT.
  - If fft_done_i and the timeout hit occur in the same cycle, done wins.
- ABORT: fft_abort_o = 1 for one cycle, the sticky flag is set, next state is FIN (error).
- FIN:
  - done_o[owner] = 1 for one cycle; err_o = 1 for the same cycle on error.
  - grant_o goes to 0 and the pointer moves to owner+1 mod NUM_REQ.
  - Next state is IDLE.
  - A requester can therefore be re-granted no sooner than 2 cycles after its done_o.
- Requester rules:
  - A requester that drops req_i during START/RUN does not cancel the frame; it still receives done_o.
  - len_i changes after the latch cycle are ignored.
- fft_done_i outside RUN is ignored.
- Sticky flag:
  - clr_err_i clears it.
  - If a clear and a set occur in the same cycle, set wins.
- Reset asserted mid-frame: immediate return to reset values; no done_o is issued.
- status_o fields:
  - [2:0] state encoding: IDLE=0, START=1, RUN=2, FIN=3, ABORT=4.
  - [3] fft_busy_i.
  - [7:4] owner index.
  - [8] sticky timeout flag.
  - [15:9] 0.
  - [31:16] optional frame counter.

Optional Feature:
- Macro: XMPL_FFT_SCHED_STATS_EN.
- When defined:
  - A 16-bit frame counter increments on each successful FIN, wrapping 0xFFFF to 0.
  - It is driven on status_o[31:16] and is cleared only by reset.
- When undefined: status_o[31:16] = 0 and no counter flops exist.

Decomposition:
- Package xmpl_fft_pkg holds:
  - the state enum,
  - status bit-position constants,
  - the default LEN_W/TMO_W localparams.
- One sub-module, xmpl_rr_arb: combinational round-robin pick (req vector plus pointer in; one-hot and index out).
- FSM, counters and registers stay in xmpl_fft_sched.

Test Plan:
- After reset, req_i=4'b0001 with len0=256 → fft_start_o at +1 cycle, fft_len_o=256, grant_o=0001. Then fft_done_i after 10 cycles → done_o=0001 for one cycle, err_o=0.
- req_i=4'b1111 held with immediate done each frame → grant order 0,1,2,3,0; pointer wraps.
- timeout_i=5 with no fft_done_i → fft_abort_o 5 cycles after RUN entry, then done_o and err_o; status_o[8]=1. clr_err_i clears it.
- timeout_i=5 with fft_done_i on the 5th RUN cycle → success: no abort, err_o=0.
- len1=0, req_i=4'b0010 → no fft_start_o; done_o=0010 and err_o pulse 1 cycle after the IDLE sample.
- reset_i asserted in RUN → grant_o=0 asynchronously and no done_o. With STATS_EN, 3 successful frames give status_o[31:16]=3.
